alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered result stage directly downstream of the ALU. It captures each ALU result, its zero/negative flags, opcode and destination tag, and maintains the architectural flag register. Pass operations leave the flags unchanged. Results are buffered in a small FIFO and presented to writeback through a valid/ready handshake, so a stalled consumer does not drop ALU results.

## Interface
Parameters:
- WIDTH, 32, datapath width; matches the ALU operand width.
- TAG_W, 5, width of the destination register tag.
- DEPTH, 2, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU-side entry is valid.
- in_ready  out  1  stage can accept an entry this cycle.
- alu_out  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_negative  in  1  ALU negative flag.
- alu_op  in  4  opcode that produced alu_out.
- in_tag  in  TAG_W  destination register tag.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  writeback accepts the head entry.
- out_data  out  WIDTH  head result.
- out_zero  out  1  architectural Z flag after the head op.
- out_negative  out  1  architectural N flag after the head op.
- out_tag  out  TAG_W  head destination tag.
- bad_op_count  out  8  saturating count of dropped illegal opcodes.

## Operation
- Push: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- Opcodes:
  - Legal: 0 add, 1 increment, 2 negate, 3 subtract, 4 pass.
  - 5–15 are illegal. A pushed illegal op is consumed, nothing is written to the FIFO, the flags are unchanged, and bad_op_count increments, saturating at 255.
- Flag register {Z,N}, updated only on a push:
  - ops 0–3 load {alu_zero, alu_negative};
  - op 4 holds the previous value.
- Each FIFO entry stores data, tag and the post-update {Z,N} snapshot. out_zero/out_negative come from that snapshot, not from the live register.
- Consistency check on each push of ops 0–3:
  - Z must equal (alu_out == 0).
  - N must equal (alu_out[WIDTH-1] && !Z).
  - A mismatch is a simulation assertion only; no hardware action.
- FIFO:
  - Write and read pointers of log2(DEPTH) bits wrap modulo DEPTH.
  - Occupancy counter runs 0..DEPTH.
  - in_ready = (count != DEPTH). It is registered-state-derived only and has no combinational path from out_ready.
  - out_valid = (count != 0). out_data/out_tag/out_zero/out_negative are driven from the head entry.
- Simultaneous push of a legal op and pop: both pointers advance and count is unchanged. This is only possible when count is between 1 and DEPTH-1.
- Full (count == DEPTH) with out_ready: the pop occurs, and in_ready rises the next cycle.
- Empty: out_valid = 0, out_data = 0, out_tag = 0, out_zero/out_negative = 0.

## Timing
- Reset values, asynchronous:
  - count = 0, pointers = 0, {Z,N} = 0, bad_op_count = 0;
  - out_valid = 0, in_ready = 1 (DEPTH > 0), out_data = 0, out_tag = 0, out_zero = 0, out_negative = 0.
- Reset mid-operation discards all buffered entries and flag state immediately; no pop is reported.
- Latency: an entry pushed at edge N is visible on outputs with out_valid = 1 in the cycle after edge N, if the FIFO was empty.
- Throughput is one entry per cycle sustained while out_ready stays high.
- Output fields of the head entry are stable while out_valid && !out_ready.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_ADD = 4'd0, OP_INC = 4'd1, OP_NEG = 4'd2, OP_SUB = 4'd3, OP_PASS = 4'd4;
  - an is_legal_op function (op <= 4);
  - the default WIDTH/TAG_W constants, shared with the ALU.
- One natural sub-module: result_fifo, a parameterised DEPTH×(WIDTH+TAG_W+2) FIFO with count, push/pop and wrap logic.
- The top level holds the flag register, the illegal-op counter and the assertions.

## Test plan
- Reset, then push op 0 with alu_out = 0x00000005, Z = 0, N = 0, tag 3, out_ready = 1 -> next cycle out_valid = 1, out_data = 5, out_tag = 3, flags 00.
- Push op 3 with result 0 (Z = 1), then op 4 with alu_out = 0xFFFFFFFF -> both entries report Z = 1, N = 0; the pass op does not set N.
- Hold out_ready = 0 and push 3 entries -> in_ready drops after 2; the third waits. Release out_ready -> data pops in order, in_ready returns the cycle after the first pop.
- Count = 1 with a simultaneous push and pop each cycle for 10 cycles -> count stays 1, pointers wrap, and the data sequence is preserved.
- Push op 7 three times -> nothing enqueued, flags unchanged, bad_op_count = 3. Then 300 illegal pushes -> bad_op_count = 255.
- Assert rst with 2 entries buffered -> out_valid = 0, count = 0, flags 00 immediately. After release, push op 1 -> normal output.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath widths, opcode encodings and opcode classification.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_TAG_W = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_INC  = 4'd1;
  localparam logic [3:0] OP_NEG  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_PASS = 4'd4;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_PASS;
  endfunction

  // Arithmetic ops overwrite the flag register; pass keeps it.
  function automatic logic op_loads_flags(input logic [3:0] op);
    return op < OP_PASS;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Power-of-two FIFO with occupancy counter; the read port shows zero while empty.
module result_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the empty mux hides stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: architectural Z/N flag register, illegal-op counter and a
// result FIFO that presents data, tag and the post-op flag snapshot to writeback.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned TAG_W = ALU_TAG_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic [3:0]       alu_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_negative,
  output logic [TAG_W-1:0] out_tag,
  output logic [7:0]       bad_op_count
);

  localparam int unsigned EntryW = WIDTH + TAG_W + 2;

  logic              push_acc, op_legal, fifo_full, fifo_empty;
  logic [1:0]        flags_q, flags_d;
  logic [7:0]        bad_q, bad_d;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;

  assign push_acc = in_valid && in_ready;
  assign op_legal = is_legal_op(alu_op);

  always_comb begin
    flags_d = flags_q;
    bad_d   = bad_q;
    if (push_acc && op_loads_flags(alu_op)) flags_d = {alu_zero, alu_negative};
    if (push_acc && !op_legal && (bad_q != 8'hFF)) bad_d = bad_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      bad_q   <= '0;
    end else begin
      flags_q <= flags_d;
      bad_q   <= bad_d;
    end
  end

  // Each entry carries the flag value as it stands after its own op.
  assign fifo_wdata = {alu_out, in_tag, flags_d};

  result_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_result_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_acc && op_legal),
    .pop_i   (out_ready),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready     = !fifo_full;
  assign out_valid    = !fifo_empty;
  assign bad_op_count = bad_q;
  assign {out_data, out_tag, out_zero, out_negative} = fifo_rdata;

  zero_flag_consistent: assert property (@(posedge clk) disable iff (rst)
    (push_acc && op_loads_flags(alu_op)) |-> (alu_zero == (alu_out == '0)));

  neg_flag_consistent: assert property (@(posedge clk) disable iff (rst)
    (push_acc && op_loads_flags(alu_op)) |-> (alu_negative == (alu_out[WIDTH-1] && !alu_zero)));

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomised and directed bench for alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, alu_zero, alu_negative;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_zero, out_negative;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [7:0]       bad_op_count;

  alu_result_stage #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_op       (alu_op),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_zero     (out_zero),
    .out_negative (out_negative),
    .out_tag      (out_tag),
    .bad_op_count (bad_op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             z;
    logic             n;
  } ent_t;

  ent_t mq[$];
  logic mz, mn;
  int   mbad;
  int   checks = 0;
  int   errors = 0;
  bit   run_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Reference model: a plain queue of accepted results plus the flag pair and counter.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mz   = 1'b0;
      mn   = 1'b0;
      mbad = 0;
    end else begin
      bit   do_pop, do_push;
      ent_t e;
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (alu_op > 4) begin
          if (mbad < 255) mbad++;
        end else begin
          if (alu_op != 4) begin
            mz = alu_zero;
            mn = alu_negative;
          end
          e.data = alu_out;
          e.tag  = in_tag;
          e.z    = mz;
          e.n    = mn;
          mq.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && run_chk) begin
      chk("out_valid", out_valid, mq.size() != 0);
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("bad_op_count", bad_op_count, mbad);
      if (mq.size() != 0) begin
        chk("out_data", out_data, mq[0].data);
        chk("out_tag", out_tag, mq[0].tag);
        chk("out_zero", out_zero, mq[0].z);
        chk("out_negative", out_negative, mq[0].n);
      end else begin
        chk("empty_fields", {out_data, out_tag, out_zero, out_negative}, 0);
      end
    end
  end

  // Drives one cycle of inputs, then returns just after the following falling edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] d,
                      input logic [TAG_W-1:0] tag, input logic rdy);
    in_valid  = v;
    alu_op    = op;
    alu_out   = d;
    in_tag    = tag;
    out_ready = rdy;
    if (op < 4) begin
      alu_zero     = (d == 0);
      alu_negative = d[WIDTH-1] && (d != 0);
    end else if (op == 4) begin
      alu_zero     = 1'b0;
      alu_negative = 1'b1;
    end else begin
      alu_zero     = 1'b0;
      alu_negative = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; alu_op = '0; alu_out = '0; in_tag = '0; out_ready = 1'b0;
    alu_zero = 1'b0; alu_negative = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fields", {out_data, out_tag, out_zero, out_negative}, 0);
    chk("rst_bad", bad_op_count, 0);
    rst = 1'b0;
    run_chk = 1'b1;

    // Single add, visible the cycle after the push
    step(1, 4'd0, 32'h5, 5'd3, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'h5);
    chk("t1_tag", out_tag, 3);
    chk("t1_flags", {out_zero, out_negative}, 2'b00);
    step(0, 4'd0, 0, 0, 1);

    // Pass keeps Z=1 from the subtract and ignores the incoming N
    step(1, 4'd3, 32'h0, 5'd1, 0);
    step(1, 4'd4, 32'hFFFF_FFFF, 5'd2, 0);
    chk("t2_sub_flags", {out_zero, out_negative}, 2'b10);
    step(0, 4'd0, 0, 0, 1);
    chk("t2_pass_data", out_data, 32'hFFFF_FFFF);
    chk("t2_pass_flags", {out_zero, out_negative}, 2'b10);
    step(0, 4'd0, 0, 0, 1);

    // Backpressure: third entry waits until the first pop frees a slot
    step(1, 4'd0, 32'h11, 5'd4, 0);
    step(1, 4'd0, 32'h22, 5'd5, 0);
    chk("t3_full", in_ready, 0);
    step(1, 4'd0, 32'h33, 5'd6, 0);
    chk("t3_still_full", in_ready, 0);
    chk("t3_head", out_data, 32'h11);
    step(1, 4'd0, 32'h33, 5'd6, 1);
    chk("t3_ready_back", in_ready, 1);
    chk("t3_head2", out_data, 32'h22);
    step(1, 4'd0, 32'h33, 5'd6, 1);
    chk("t3_head3", out_data, 32'h33);
    step(0, 4'd0, 0, 0, 1);

    // Streaming at occupancy one
    step(1, 4'd1, 32'd100, 5'd0, 0);
    for (int i = 0; i < 10; i++) step(1, 4'd1, 32'(101 + i), 5'(i), 1);
    chk("t4_last", out_data, 32'd110);
    chk("t4_ready", in_ready, 1);
    step(0, 4'd0, 0, 0, 1);

    // Illegal ops: dropped, flags held, counter saturates
    step(1, 4'd3, 32'h0, 5'd7, 1);
    step(0, 4'd0, 0, 0, 1);
    repeat (3) step(1, 4'd7, 32'h1234, 5'd8, 1);
    chk("t5_bad3", bad_op_count, 3);
    chk("t5_empty", out_valid, 0);
    step(1, 4'd4, 32'h9, 5'd9, 0);
    chk("t5_flags_held", {out_zero, out_negative}, 2'b10);
    step(0, 4'd0, 0, 0, 1);
    repeat (300) step(1, 4'(8 + $urandom_range(0, 7)), $urandom, 5'd0, 1);
    chk("t5_sat", bad_op_count, 255);

    // Random traffic
    repeat (600) begin
      logic [3:0]       op;
      logic [WIDTH-1:0] d;
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      d  = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      step(1'($urandom_range(0, 3) != 0), op, d, 5'($urandom), 1'($urandom_range(0, 9) < 7));
    end
    repeat (3) step(0, 4'd0, 0, 0, 1);

    // Asynchronous reset with two buffered entries
    step(1, 4'd3, 32'h0, 5'd1, 0);
    step(1, 4'd0, 32'h8000_0000, 5'd2, 0);
    chk("t6_full", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_fields", {out_data, out_tag, out_zero, out_negative}, 0);
    chk("t6_rst_bad", bad_op_count, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(1, 4'd1, 32'h7, 5'd9, 1);
    chk("t6_post_valid", out_valid, 1);
    chk("t6_post_data", out_data, 32'h7);
    chk("t6_post_tag", out_tag, 9);
    chk("t6_post_flags", {out_zero, out_negative}, 2'b00);
    step(0, 4'd0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
